image_rom_arbiter: RTL and testbench
====================================

// Module: image_rom_arbiter
// PURPOSE
//  Shares one single-port image ROM (15-bit address, 12-bit RGB, 1-cycle registered read)
//  between N_REQ pixel-fetch clients such as sprite/character draw stages.
//  Round-robin arbitration with optional locked bursts, so one client can stream a full image row.
//  Sits between the draw_* pipeline stages and one image_rom_* instance.
// PARAMETERS
//  N_REQ        4    number of requesters (2..8)
//  ADDR_W       15   ROM address width
//  DATA_W       12   ROM data width, {r,g,b} 4 bits each
//  MAX_BURST    64   max consecutive grants to a locked owner (power of 2 not required, >=1)
//  IDLE_TIMEOUT 16   cycles a locked owner may leave req_i low before the lock is revoked
// PORTS
//  clk         in   1               system clock, all logic on rising edge
//  rst_n       in   1               synchronous reset, active low
//  req_i       in   N_REQ           per-client read request, held until granted
//  lock_i      in   N_REQ           per-client burst lock request, sampled with req_i
//  addr_i      in   N_REQ*ADDR_W    packed client addresses, client k at [k*ADDR_W +: ADDR_W]
//  gnt_o       out  N_REQ           one-hot (or zero) grant, combinational, same cycle as accept
//  rvalid_o    out  N_REQ           one-hot read-data valid, exactly 1 cycle after gnt_o
//  rdata_o     out  DATA_W          read data, broadcast to all clients, valid with rvalid_o
//  rom_addr_o  out  ADDR_W          address to the ROM
//  rom_rgb_i   in   DATA_W          ROM registered output
//  busy_o      out  1               1 while state is LOCKED
//  owner_o     out  $clog2(N_REQ)   index of last granted client / current lock owner
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=ARB, rr_ptr=0, owner_o=0, burst_cnt=0, idle_cnt=0,
//    rvalid_o=0, addr_hold=0; gnt_o=0 while rst_n=0; busy_o=0. In-flight read discarded (no rvalid).
//  - Handshake: transfer when req_i[k]&gnt_o[k]. Client holds addr_i/req_i stable until granted;
//    at most one grant per cycle; gnt_o never asserted to a client with req_i low.
//  - rom_addr_o = addr_i[winner] in a grant cycle, else addr_hold (last granted address).
//  - rvalid_o <= gnt_o (registered); rdata_o = rom_rgb_i pass-through. Read latency 1 cycle.
//  - State ARB: winner = first k with req_i[k], searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
//    On grant: rr_ptr <= (winner+1) mod N_REQ; owner_o <= winner.
//    If lock_i[winner]=1 and MAX_BURST>1: -> LOCKED, burst_cnt <= 1, idle_cnt <= 0.
//  - State LOCKED: only owner may be granted; other requests wait (no grant, no loss).
//    req_i[owner]=1: grant, burst_cnt++, idle_cnt <= 0.
//    req_i[owner]=0: no grant, idle_cnt++.
//    Exit to ARB (next cycle arbitrates normally, rr_ptr unchanged) when any of:
//      a) grant given with lock_i[owner]=0 (this grant is the last beat of the burst);
//      b) grant given and burst_cnt+1 == MAX_BURST (the MAX_BURST-th beat);
//      c) idle_cnt+1 == IDLE_TIMEOUT in a no-request cycle;
//      d) lock_i[owner]=0 and req_i[owner]=0 (immediate release, no grant).
//  - Simultaneous requests in ARB: strict rotation from rr_ptr; pointer wraps N_REQ-1 -> 0.
//  - Counters saturate-free: burst_cnt width $clog2(MAX_BURST+1), idle_cnt $clog2(IDLE_TIMEOUT+1);
//    both cleared on ARB entry.
//  - busy_o = (state==LOCKED), registered with state.
//  - Reset mid-burst: return to ARB, no rvalid for the beat granted in the reset cycle.
// TESTING
//  1 Single client: req_i=4'b0001, addr=0x0123 -> gnt_o=0001 same cycle, rom_addr_o=0x0123,
//    rvalid_o=0001 next cycle with rdata_o = ROM[0x0123].
//  2 Round robin: req_i=4'b1111 held, lock_i=0 -> grants 0,1,2,3,0,... one per cycle,
//    rvalid_o follows gnt_o by 1 cycle, no gaps.
//  3 Burst: client 2 req+lock held, client 0 requesting, MAX_BURST=64 -> 64 consecutive grants
//    to 2, busy_o=1 throughout, then next cycle grant to 0, busy_o=0.
//  4 Idle timeout: client 1 locks, drops req_i, keeps lock_i=1, client 3 requests ->
//    no grants for 16 cycles, then ARB, client 3 granted on cycle 17.
//  5 Early release: locked client 1 grants with lock_i=0 on its 5th beat -> ARB next cycle,
//    burst_cnt=0, rr_ptr=2 so client 2 wins over 0 when both request.
//  6 Reset mid-burst: rst_n=0 for 1 cycle during LOCKED -> gnt_o=0, next-cycle rvalid_o=0,
//    busy_o=0, rr_ptr=0, client 0 wins first after release.

Source files
------------

// File: rtl/image_rom_arbiter.sv
// Round-robin arbiter sharing one single-port image ROM between N_REQ pixel-fetch clients,
// with optional locked bursts so one client can stream a whole image row.
module image_rom_arbiter #(
  parameter int N_REQ        = 4,
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 12,
  parameter int MAX_BURST    = 64,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0]          lock_i,
  input  logic [N_REQ*ADDR_W-1:0]   addr_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [N_REQ-1:0]          rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic [ADDR_W-1:0]         rom_addr_o,
  input  logic [DATA_W-1:0]         rom_rgb_i,
  output logic                      busy_o,
  output logic [$clog2(N_REQ)-1:0]  owner_o
);

  // Handshake: a read transfers in the cycle where req_i[k] & gnt_o[k]; the client holds
  // req_i/addr_i stable until then, and rvalid_o[k] with rdata_o follows exactly one cycle later.

  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam bit LOCK_EN = (MAX_BURST > 1);

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]        state_q;
  logic [IW-1:0]     rr_ptr_q;
  logic [IW-1:0]     owner_q;
  logic [BW-1:0]     burst_cnt_q;
  logic [TW-1:0]     idle_cnt_q;
  logic [N_REQ-1:0]  rvalid_q;
  logic [ADDR_W-1:0] addr_hold_q;

  logic              arb_found;
  logic [IW-1:0]     arb_idx;
  logic              grant;
  logic [IW-1:0]     win_idx;
  logic              win_lock;
  logic              last_beat;
  logic              idle_expire;
  int                scan_k;

  // Rotating priority scan starting at rr_ptr_q.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    scan_k    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_k = (int'(rr_ptr_q) + i) % N_REQ;
      if (!arb_found && req_i[scan_k]) begin
        arb_found = 1'b1;
        arb_idx   = IW'(scan_k);
      end
    end
  end

  always_comb begin
    grant   = 1'b0;
    win_idx = owner_q;
    if (rst_n) begin
      if (state_q == ST_ARB) begin
        grant   = arb_found;
        win_idx = arb_idx;
      end else begin
        grant   = req_i[owner_q];
        win_idx = owner_q;
      end
    end
  end

  assign win_lock    = lock_i[win_idx];
  assign last_beat   = !lock_i[owner_q] || (burst_cnt_q + BW'(1) == BW'(MAX_BURST));
  assign idle_expire = !lock_i[owner_q] || (idle_cnt_q + TW'(1) == TW'(IDLE_TIMEOUT));

  assign gnt_o      = grant ? (N_REQ'(1) << win_idx) : '0;
  assign rom_addr_o = grant ? addr_i[win_idx*ADDR_W +: ADDR_W] : addr_hold_q;
  assign rvalid_o   = rvalid_q;
  assign rdata_o    = rom_rgb_i;
  assign busy_o     = (state_q == ST_LOCKED);
  assign owner_o    = owner_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ARB;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      idle_cnt_q  <= '0;
      rvalid_q    <= '0;
      addr_hold_q <= '0;
    end else begin
      rvalid_q <= gnt_o;
      if (grant) begin
        addr_hold_q <= addr_i[win_idx*ADDR_W +: ADDR_W];
      end
      if (state_q == ST_ARB) begin
        if (grant) begin
          rr_ptr_q <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
          owner_q  <= win_idx;
          if (win_lock && LOCK_EN) begin
            state_q     <= ST_LOCKED;
            burst_cnt_q <= BW'(1);
            idle_cnt_q  <= '0;
          end
        end
      end else begin
        // Locked: rr_ptr_q is left alone so arbitration resumes where it stopped.
        if (grant) begin
          idle_cnt_q <= '0;
          if (last_beat) begin
            state_q     <= ST_ARB;
            burst_cnt_q <= '0;
          end else begin
            burst_cnt_q <= burst_cnt_q + BW'(1);
          end
        end else if (idle_expire) begin
          state_q     <= ST_ARB;
          burst_cnt_q <= '0;
          idle_cnt_q  <= '0;
        end else begin
          idle_cnt_q <= idle_cnt_q + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Directed and randomized bench for image_rom_arbiter against a rule-level model and a ROM scoreboard.
module tb_image_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 15;
  localparam int DW = 12;
  localparam int MB = 64;
  localparam int TO = 16;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  lock;
  logic [N*AW-1:0] addr;
  logic [N-1:0]  gnt;
  logic [N-1:0]  rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_rgb;
  logic          busy;
  logic [1:0]    owner;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit            m_locked;
  int            m_ptr, m_owner, m_beats, m_idle;
  logic [N-1:0]  m_prev_gnt;
  logic [AW-1:0] m_hold;
  logic [DW-1:0] exp_q[$];
  logic [N-1:0]  last_gnt_exp;

  image_rom_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .IDLE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .lock_i(lock), .addr_i(addr),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .rom_addr_o(rom_addr),
    .rom_rgb_i(rom_rgb), .busy_o(busy), .owner_o(owner)
  );

  // ---- clock / reset / ROM ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    logic [31:0] t;
    t = ({17'b0, a} * 32'd13) ^ ({17'b0, a} >> 5) ^ 32'h5a5;
    return t[DW-1:0];
  endfunction

  always @(posedge clk) rom_rgb <= rom_f(rom_addr);

  // ---- scoreboard ----
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_ptr = 0; m_owner = 0; m_beats = 0; m_idle = 0;
    m_prev_gnt = '0; m_hold = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int win;
    logic [N-1:0]  eg;
    logic [AW-1:0] ea;
    win = -1;
    if (rst_n) begin
      if (!m_locked) begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (m_ptr + i) % N;
          if (win < 0 && req[k]) win = k;
        end
      end else if (req[m_owner]) begin
        win = m_owner;
      end
    end
    eg = (win >= 0) ? N'(1 << win) : '0;
    ea = (win >= 0) ? addr[win*AW +: AW] : m_hold;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("busy", 32'(busy), 32'(m_locked));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("rvalid", 32'(rvalid), 32'(m_prev_gnt));
    if (rst_n) chk("rom_addr", 32'(rom_addr), 32'(ea));
    if (m_prev_gnt != '0) begin
      if (exp_q.size() > 0) chk("rdata", 32'(rdata), 32'(exp_q.pop_front()));
      else chk("rdata_queue_empty", 32'(exp_q.size()), 32'd1);
    end
    last_gnt_exp = eg;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_prev_gnt = eg;
      if (win >= 0) begin
        m_hold = ea;
        exp_q.push_back(rom_f(ea));
      end
      if (!m_locked) begin
        if (win >= 0) begin
          m_ptr = (win + 1) % N;
          m_owner = win;
          if (lock[win] && MB > 1) begin
            m_locked = 1; m_beats = 1; m_idle = 0;
          end
        end
      end else if (win >= 0) begin
        m_idle = 0;
        if (!lock[m_owner] || m_beats + 1 == MB) begin
          m_locked = 0; m_beats = 0;
        end else begin
          m_beats++;
        end
      end else if (!lock[m_owner] || m_idle + 1 == TO) begin
        m_locked = 0; m_beats = 0; m_idle = 0;
      end else begin
        m_idle++;
      end
    end
  endtask

  // ---- driver ----
  task automatic cycle(input logic rn, input logic [N-1:0] rq, input logic [N-1:0] lk,
                       input logic [N*AW-1:0] ad);
    @(negedge clk);
    rst_n = rn; req = rq; lock = lk; addr = ad;
    #1;
    model_step();
  endtask

  logic [N*AW-1:0] a_vec;
  logic [N-1:0]    pending;
  logic [N-1:0]    lk_r;
  int              n, at;

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; addr = '0;
    repeat (2) @(posedge clk);
    model_reset();
    a_vec = {15'h3333, 15'h2222, 15'h1111, 15'h0123};

    // reset state
    cycle(1, 4'b0000, 4'b0000, a_vec);

    // 1: single client
    cycle(1, 4'b0001, 4'b0000, a_vec);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_rom_addr", 32'(rom_addr), 32'h0123);
    cycle(1, 4'b0000, 4'b0000, a_vec);
    chk("t1_rvalid", 32'(rvalid), 32'h1);
    chk("t1_rdata", 32'(rdata), 32'(rom_f(15'h0123)));

    // 2: round robin from reset
    cycle(0, 4'b0000, 4'b0000, a_vec);
    for (int i = 0; i < 8; i++) begin
      a_vec = {15'($urandom), 15'($urandom), 15'($urandom), 15'($urandom)};
      cycle(1, 4'b1111, 4'b0000, a_vec);
      chk("t2_rotation", 32'(gnt), 32'(1 << (i % 4)));
    end
    cycle(1, 4'b0000, 4'b0000, a_vec);

    // 3: full burst to client 2 while client 0 waits
    n = 0;
    for (int i = 0; i < MB; i++) begin
      cycle(1, (i == 0) ? 4'b0100 : 4'b0101, 4'b0100, a_vec);
      if (gnt === 4'b0100) n++;
      if (i > 0) chk("t3_busy", 32'(busy), 32'd1);
    end
    chk("t3_burst_len", 32'(n), 32'(MB));
    cycle(1, 4'b0101, 4'b0100, a_vec);
    chk("t3_next_gnt", 32'(gnt), 32'h1);
    chk("t3_busy_after", 32'(busy), 32'd0);
    cycle(1, 4'b0100, 4'b0100, a_vec);
    cycle(1, 4'b0000, 4'b0000, a_vec);
    cycle(1, 4'b0000, 4'b0000, a_vec);

    // 4: idle timeout
    cycle(1, 4'b0010, 4'b0010, a_vec);
    at = 0;
    for (int i = 1; i <= 24; i++) begin
      cycle(1, 4'b1000, 4'b0010, a_vec);
      if (gnt === 4'b1000) begin
        at = i;
        break;
      end
    end
    chk("t4_timeout_cycle", 32'(at), 32'(TO + 1));
    cycle(1, 4'b0000, 4'b0000, a_vec);

    // 5: early release on 5th beat
    for (int i = 0; i < 4; i++) cycle(1, 4'b0010, 4'b0010, a_vec);
    cycle(1, 4'b0010, 4'b0000, a_vec);
    chk("t5_last_beat", 32'(gnt), 32'h2);
    cycle(1, 4'b0101, 4'b0000, a_vec);
    chk("t5_ptr_after", 32'(gnt), 32'h4);
    chk("t5_busy", 32'(busy), 32'd0);
    cycle(1, 4'b0001, 4'b0000, a_vec);
    cycle(1, 4'b0000, 4'b0000, a_vec);

    // 6: reset mid-burst
    for (int i = 0; i < 3; i++) cycle(1, 4'b0100, 4'b0100, a_vec);
    cycle(0, 4'b0100, 4'b0100, a_vec);
    chk("t6_gnt_in_reset", 32'(gnt), 32'h0);
    cycle(1, 4'b0101, 4'b0100, a_vec);
    chk("t6_first_after", 32'(gnt), 32'h1);
    chk("t6_rvalid", 32'(rvalid), 32'h0);
    chk("t6_busy", 32'(busy), 32'd0);
    cycle(1, 4'b0100, 4'b0100, a_vec);
    cycle(1, 4'b0000, 4'b0000, a_vec);
    cycle(1, 4'b0000, 4'b0000, a_vec);

    // randomized traffic, clients hold requests until granted
    pending = '0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pending[k] && $urandom_range(0, 9) < 4) begin
          pending[k] = 1'b1;
          a_vec[k*AW +: AW] = AW'($urandom_range(0, 32767));
        end
        lk_r[k] = ($urandom_range(0, 3) == 0);
      end
      cycle((c % 97 == 96) ? 1'b0 : 1'b1, pending, lk_r, a_vec);
      pending = pending & ~last_gnt_exp;
    end
    for (int i = 0; i < 3; i++) cycle(1, 4'b0000, 4'b0000, a_vec);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
